// File: rtl/pio_dma_sched_pkg.sv
// Shared definitions for the PIO DMA write scheduler: FSM state encoding and default TLP size.
package pio_dma_sched_pkg;

  localparam int DMA_TLP_WORDS = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_START = 3'd2,
    S_BURST = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/pio_dma_addr_gen.sv
// DMA address generator: loads the host base, advances per TLP, counts completed TLPs.
// Optional DMA_HALF_IRQ_EN adds the half-buffer compare output.
module pio_dma_addr_gen #(
  parameter int TLP_WORDS = 32,
  parameter int NTLP_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [29:0]       host_base,
  input  logic [NTLP_W-1:0] buf_ntlp,
  output logic [29:0]       dma_addr,
  output logic [NTLP_W-1:0] tlp_cnt,
  output logic              cnt_done
`ifdef DMA_HALF_IRQ_EN
  , output logic            half_hit
`endif
);

  logic [NTLP_W-1:0] ntlp_lat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dma_addr <= '0;
      tlp_cnt  <= '0;
      ntlp_lat <= '0;
    end else if (load) begin
      dma_addr <= host_base;
      tlp_cnt  <= '0;
      ntlp_lat <= buf_ntlp;
    end else if (advance) begin
      // 30-bit DWORD address wraps naturally at the top of the 4 GB space
      dma_addr <= dma_addr + 30'(TLP_WORDS);
      if (tlp_cnt != ntlp_lat) tlp_cnt <= tlp_cnt + 1'b1;
    end
  end

  assign cnt_done = (tlp_cnt == ntlp_lat);

`ifdef DMA_HALF_IRQ_EN
  assign half_hit = (ntlp_lat >= NTLP_W'(2)) && (tlp_cnt == (ntlp_lat >> 1));
`endif

endmodule

// File: rtl/pio_dma_sched.sv
// Host-bound DMA write TLP scheduler for the PIO endpoint TX engine.
// Optional DMA_HALF_IRQ_EN adds a half-buffer interrupt pulse and the irq_half port.
//
// state   | meaning
// IDLE    | no buffer active, waiting for run + bus master + nonzero TLP count
// ARM     | waiting for a full TLP in the FIFO and no pending read completion
// START   | one-cycle dma_start pulse to the TX engine
// BURST   | counting payload words consumed by the TX engine
// GAP     | forced idle spacing after a TLP, then decide next TLP or done
// DONE    | one-cycle buffer-done interrupt request
module pio_dma_sched
  import pio_dma_sched_pkg::*;
#(
  parameter int TLP_WORDS = DMA_TLP_WORDS,
  parameter int NTLP_W    = 16,
  parameter int GAP_CYC   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_bus_mstr_enable,
  input  logic              ctrl_run,
  input  logic              ctrl_abort,
  input  logic [29:0]       host_base,
  input  logic [NTLP_W-1:0] buf_ntlp,
  input  logic [15:0]       fifo_words,
  input  logic              req_compl,
  input  logic              dma_rd_en,
  output logic              dma_start,
  output logic [29:0]       dma_addr,
  output logic              dma_busy,
  output logic [NTLP_W-1:0] tlp_cnt,
  output logic              irq_req
`ifdef DMA_HALF_IRQ_EN
  , output logic            irq_half
`endif
);

  localparam int              WC_W     = $clog2(TLP_WORDS) + 1;
  localparam logic [WC_W-1:0] WC_LAST  = WC_W'(TLP_WORDS - 1);
  localparam logic [3:0]      GAP_LOAD = (GAP_CYC == 0) ? 4'd0 : 4'(GAP_CYC - 1);

  state_t          state_q, state_d;
  logic [WC_W-1:0] word_cnt;
  logic [3:0]      gap_cnt;
  logic            abort_lat;
  logic            cnt_done;
  logic            load;
  logic            last_word;
  logic            start_ok;
  logic            stop_req;
`ifdef DMA_HALF_IRQ_EN
  logic            half_hit;
`endif

  assign load      = (state_q == S_IDLE) && ctrl_run && cfg_bus_mstr_enable && (buf_ntlp != '0);
  assign last_word = (state_q == S_BURST) && dma_rd_en && (word_cnt == WC_LAST);
  assign start_ok  = cfg_bus_mstr_enable && !req_compl && (fifo_words >= 16'(TLP_WORDS));
  assign stop_req  = ctrl_abort || !ctrl_run;
  assign dma_busy  = (state_q != S_IDLE);

  pio_dma_addr_gen #(
    .TLP_WORDS(TLP_WORDS),
    .NTLP_W   (NTLP_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .advance  (last_word),
    .host_base(host_base),
    .buf_ntlp (buf_ntlp),
    .dma_addr (dma_addr),
    .tlp_cnt  (tlp_cnt),
    .cnt_done (cnt_done)
`ifdef DMA_HALF_IRQ_EN
    , .half_hit(half_hit)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    dma_start = 1'b0;
    irq_req   = 1'b0;
`ifdef DMA_HALF_IRQ_EN
    irq_half  = 1'b0;
`endif
    case (state_q)
      S_IDLE:  if (load) state_d = S_ARM;
      S_ARM: begin
        if (abort_lat || stop_req) state_d = S_DONE;
        else if (start_ok)         state_d = S_START;
      end
      S_START: begin
        dma_start = 1'b1;
        state_d   = S_BURST;
      end
      S_BURST: if (last_word) state_d = S_GAP;
      S_GAP: begin
        if (gap_cnt == 4'd0) begin
`ifdef DMA_HALF_IRQ_EN
          if (half_hit) begin
            irq_req  = 1'b1;
            irq_half = 1'b1;
          end
`endif
          if (cnt_done || abort_lat || stop_req || !cfg_bus_mstr_enable) state_d = S_DONE;
          else                                                          state_d = S_ARM;
        end
      end
      S_DONE: begin
        irq_req = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt  <= '0;
      gap_cnt   <= '0;
      abort_lat <= 1'b0;
    end else begin
      if (state_q == S_START)                  word_cnt <= '0;
      else if (state_q == S_BURST && dma_rd_en) word_cnt <= word_cnt + 1'b1;

      if (last_word)                               gap_cnt <= GAP_LOAD;
      else if (state_q == S_GAP && gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;

      // losing bus mastership once a TLP is under way ends the buffer after that TLP
      if (state_q == S_IDLE)
        abort_lat <= 1'b0;
      else if (stop_req ||
               (!cfg_bus_mstr_enable && state_q inside {S_START, S_BURST, S_GAP}))
        abort_lat <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pio_dma_sched.sv
// Scoreboard bench for pio_dma_sched: expected TLP addresses and buffer-end counts are queued
// by the stimulus; a negedge monitor pops and compares on every dma_start and irq_req.
module tb_pio_dma_sched;

  localparam int TW  = 32;
  localparam int NW  = 16;
  localparam int GAP = 4;

  logic          clk;
  logic          rst_n;
  logic          cfg_bus_mstr_enable;
  logic          ctrl_run;
  logic          ctrl_abort;
  logic [29:0]   host_base;
  logic [NW-1:0] buf_ntlp;
  logic [15:0]   fifo_words;
  logic          req_compl;
  logic          dma_rd_en;
  logic          dma_start;
  logic [29:0]   dma_addr;
  logic          dma_busy;
  logic [NW-1:0] tlp_cnt;
  logic          irq_req;
`ifdef DMA_HALF_IRQ_EN
  logic          irq_half;
`endif

  pio_dma_sched #(.TLP_WORDS(TW), .NTLP_W(NW), .GAP_CYC(GAP)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cfg_bus_mstr_enable(cfg_bus_mstr_enable),
    .ctrl_run           (ctrl_run),
    .ctrl_abort         (ctrl_abort),
    .host_base          (host_base),
    .buf_ntlp           (buf_ntlp),
    .fifo_words         (fifo_words),
    .req_compl          (req_compl),
    .dma_rd_en          (dma_rd_en),
    .dma_start          (dma_start),
    .dma_addr           (dma_addr),
    .dma_busy           (dma_busy),
    .tlp_cnt            (tlp_cnt),
    .irq_req            (irq_req)
`ifdef DMA_HALF_IRQ_EN
    , .irq_half         (irq_half)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [29:0] exp_addr_q[$];
  int          exp_cnt_q[$];
  int          start_cnt = 0;
  int          irq_cnt   = 0;

  bit resp_active = 0;
  int resp_words  = 0;
  bit rd_real     = 0;
  bit noise_en    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // TX engine model: consumes TW words per dma_start with random stalls; strays outside a TLP
  initial begin
    dma_rd_en = 1'b0;
    forever begin
      @(posedge clk); #1;
      dma_rd_en = 1'b0;
      rd_real   = 1'b0;
      if (!rst_n) resp_active = 0;
      else if (dma_start) begin
        resp_active = 1;
        resp_words  = 0;
        dma_rd_en   = 1'($urandom_range(1));
      end else if (resp_active) begin
        if ($urandom_range(3) != 0) begin
          dma_rd_en = 1'b1;
          rd_real   = 1'b1;
          resp_words++;
          if (resp_words == TW) resp_active = 0;
        end
      end else begin
        dma_rd_en = ($urandom_range(7) == 0);
      end
      if (noise_en) begin
        req_compl  = ($urandom_range(3) == 0);
        fifo_words = 16'($urandom_range(64, 24));
      end
    end
  end

  // Monitor
  initial begin
    logic [29:0] cur_addr;
    int  since_word;
    int  mon_words;
    bit  buf_first;
    bit  tlp_open;
    logic        prev_req;
    logic        prev_bme;
    logic [15:0] prev_fifo;
    cur_addr = '0; since_word = 1000; mon_words = 0; buf_first = 1; tlp_open = 0;
    prev_req = 1'b0; prev_bme = 1'b0; prev_fifo = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        buf_first = 1; tlp_open = 0; mon_words = 0; since_word = 1000;
      end else begin
        since_word++;
        if (dma_start) begin
          start_cnt++;
          if (tlp_open) chk("words_per_tlp", 32'(mon_words), 32'(TW));
          chk("start_req_compl_clear", 32'(prev_req), 32'd0);
          chk("start_bus_master", 32'(prev_bme), 32'd1);
          chk("start_fifo_full_tlp", 32'(prev_fifo >= 16'(TW)), 32'd1);
          if (!buf_first) chk("gap_before_start", 32'(since_word >= GAP + 2), 32'd1);
          if (exp_addr_q.size() == 0) chk("unexpected_dma_start", 32'(dma_addr), 32'hFFFF_FFFF);
          else begin
            cur_addr = exp_addr_q.pop_front();
            chk("start_addr", 32'(dma_addr), 32'(cur_addr));
          end
          buf_first = 0; tlp_open = 1; mon_words = 0;
        end
        if (dma_rd_en && rd_real) begin
          mon_words++;
          since_word = 0;
          chk("addr_stable_in_burst", 32'(dma_addr), 32'(cur_addr));
        end
        if (irq_req) begin
          irq_cnt++;
          if (tlp_open) begin
            chk("words_per_tlp", 32'(mon_words), 32'(TW));
            chk("gap_before_irq", 32'(since_word >= GAP + 1), 32'd1);
          end
          if (exp_cnt_q.size() == 0) chk("unexpected_irq_req", 32'(tlp_cnt), 32'hFFFF_FFFF);
          else chk("irq_tlp_cnt", 32'(tlp_cnt), 32'(exp_cnt_q.pop_front()));
          buf_first = 1; tlp_open = 0;
        end
      end
      prev_req  = req_compl;
      prev_bme  = cfg_bus_mstr_enable;
      prev_fifo = fifo_words;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  // Reference: TLP i of a buffer goes to base + i*TW (30-bit wrap); buffer ends with cnt TLPs done
  task automatic push_buf(input logic [29:0] base, input int n_starts, input int cnt);
    for (int i = 0; i < n_starts; i++) exp_addr_q.push_back(base + 30'(i * TW));
    if (cnt >= 0) exp_cnt_q.push_back(cnt);
  endtask

  task automatic start_buf(input logic [29:0] base, input int ntlp);
    host_base = base;
    buf_ntlp  = NW'(ntlp);
    ctrl_run  = 1'b1;
  endtask

  task automatic wait_irq(input int target, input int budget);
    int k = 0;
    while (irq_cnt < target && k < budget) begin tick(); k++; end
    chk("irq_within_budget", 32'(irq_cnt >= target), 32'd1);
    ctrl_run = 1'b0;
  endtask

  task automatic wait_starts(input int target, input int budget);
    int k = 0;
    while (start_cnt < target && k < budget) begin tick(); k++; end
    chk("start_within_budget", 32'(start_cnt >= target), 32'd1);
  endtask

  task automatic wait_words(input int w, input int budget);
    int k = 0;
    while (!(resp_active && resp_words >= w) && k < budget) begin tick(); k++; end
    chk("words_within_budget", 32'(resp_active && resp_words >= w), 32'd1);
  endtask

  initial begin
    int s0;
    logic [29:0] b;
    int n;
    rst_n = 1'b0; cfg_bus_mstr_enable = 1'b1; ctrl_run = 1'b0; ctrl_abort = 1'b0;
    host_base = '0; buf_ntlp = '0; fifo_words = '0; req_compl = 1'b0;
    tick(3);
    chk("rst_dma_start", 32'(dma_start), 32'd0);
    chk("rst_dma_addr", 32'(dma_addr), 32'd0);
    chk("rst_dma_busy", 32'(dma_busy), 32'd0);
    chk("rst_tlp_cnt", 32'(tlp_cnt), 32'd0);
    chk("rst_irq_req", 32'(irq_req), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // buf_ntlp = 0 never leaves IDLE
    fifo_words = 16'd32;
    start_buf(30'h100, 0);
    tick(10);
    chk("ntlp0_stays_idle", 32'(dma_busy), 32'd0);
    ctrl_run = 1'b0;
    tick(2);

    // single TLP
    push_buf(30'h100, 1, 1);
    start_buf(30'h100, 1);
    wait_irq(irq_cnt + 1, 500);
    chk("single_tlp_cnt", 32'(tlp_cnt), 32'd1);
    chk("idle_after_buffer", 32'(dma_busy), 32'd0);
    tick(3);

    // address wrap
    push_buf(30'h3FFF_FFF0, 2, 2);
    start_buf(30'h3FFF_FFF0, 2);
    wait_irq(irq_cnt + 1, 1000);
    tick(3);

    // completion priority in ARM, then req_compl rising mid-burst
    req_compl = 1'b1;
    push_buf(30'h40, 1, 1);
    s0 = start_cnt;
    start_buf(30'h40, 1);
    tick(10);
    chk("no_start_while_req_compl", 32'(start_cnt), 32'(s0));
    chk("armed_busy", 32'(dma_busy), 32'd1);
    req_compl = 1'b0;
    tick(2);
    chk("start_after_req_compl_falls", 32'(start_cnt), 32'(s0 + 1));
    wait_words(4, 200);
    req_compl = 1'b1;
    wait_irq(irq_cnt + 1, 500);
    req_compl = 1'b0;
    tick(3);

    // FIFO starvation
    fifo_words = 16'd31;
    push_buf(30'h800, 1, 1);
    s0 = start_cnt;
    start_buf(30'h800, 1);
    tick(50);
    chk("starved_no_start", 32'(start_cnt), 32'(s0));
    chk("starved_busy", 32'(dma_busy), 32'd1);
    fifo_words = 16'd32;
    tick(2);
    chk("start_after_fifo_fill", 32'(start_cnt), 32'(s0 + 1));
    wait_irq(irq_cnt + 1, 500);
    tick(3);

    // abort at word 10 of TLP 1 of 4
    push_buf(30'h1000, 1, 1);
    start_buf(30'h1000, 4);
    wait_words(10, 300);
    ctrl_abort = 1'b1; tick(); ctrl_abort = 1'b0;
    wait_irq(irq_cnt + 1, 500);
    chk("abort_tlp_cnt", 32'(tlp_cnt), 32'd1);
    tick(3);

    // abort while armed
    fifo_words = 16'd0;
    push_buf(30'h2000, 0, 0);
    start_buf(30'h2000, 2);
    tick(5);
    ctrl_abort = 1'b1; tick(); ctrl_abort = 1'b0;
    wait_irq(irq_cnt + 1, 50);
    fifo_words = 16'd32;
    tick(3);

    // run dropped during TLP 2 of 3
    push_buf(30'h3000, 2, 2);
    s0 = start_cnt;
    start_buf(30'h3000, 3);
    wait_starts(s0 + 2, 500);
    wait_words(3, 300);
    ctrl_run = 1'b0;
    wait_irq(irq_cnt + 1, 500);
    tick(3);

    // bus master disabled mid-burst
    push_buf(30'h4000, 1, 1);
    start_buf(30'h4000, 3);
    wait_words(10, 300);
    cfg_bus_mstr_enable = 1'b0;
    wait_irq(irq_cnt + 1, 500);
    cfg_bus_mstr_enable = 1'b1;
    tick(3);

    // ring mode: run held high re-arms at the same base
    push_buf(30'h200, 1, 1);
    push_buf(30'h200, 1, 1);
    start_buf(30'h200, 1);
    wait_irq(irq_cnt + 2, 1000);
    tick(3);

    // random buffers with completion/FIFO noise and mid-buffer config changes
    noise_en = 1;
    for (int r = 0; r < 6; r++) begin
      b = 30'($urandom);
      n = int'($urandom_range(5, 1));
      push_buf(b, n, n);
      start_buf(b, n);
      tick(3);
      host_base = 30'($urandom);
      buf_ntlp  = NW'($urandom_range(9, 1));
      wait_irq(irq_cnt + 1, 5000);
      tick(2);
    end
    noise_en = 0;
    tick();
    req_compl = 1'b0; fifo_words = 16'd32;
    tick(3);

    // reset at word 5
    push_buf(30'h5000, 1, -1);
    s0 = start_cnt;
    start_buf(30'h5000, 3);
    wait_words(5, 300);
    #1;
    rst_n = 1'b0;
    ctrl_run = 1'b0;
    #1;
    chk("async_rst_dma_start", 32'(dma_start), 32'd0);
    chk("async_rst_dma_addr", 32'(dma_addr), 32'd0);
    chk("async_rst_dma_busy", 32'(dma_busy), 32'd0);
    chk("async_rst_tlp_cnt", 32'(tlp_cnt), 32'd0);
    chk("async_rst_irq_req", 32'(irq_req), 32'd0);
    exp_addr_q.delete();
    exp_cnt_q.delete();
    tick(3);
    rst_n = 1'b1;
    s0 = start_cnt;
    tick(20);
    chk("no_start_after_reset", 32'(start_cnt), 32'(s0));
    chk("idle_after_reset", 32'(dma_busy), 32'd0);
    push_buf(30'h6000, 2, 2);
    start_buf(30'h6000, 2);
    wait_irq(irq_cnt + 1, 1000);
    tick(5);

    chk("all_starts_consumed", 32'(exp_addr_q.size()), 32'd0);
    chk("all_irqs_consumed", 32'(exp_cnt_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
